timer_irq: RTL and testbench

Programmable down-counting timer that acts as the interrupt source feeding one bit of the CP0 `HWInt[5:0]` input. It sits on the memory-mapped peripheral bus behind the bridge, is configured by `sw`/`lw` from the CPU, and raises `irq` when its count expires. CP0 samples `irq` into Cause.IP every cycle and decides whether to take the interrupt; this block never sees acknowledge signals, only register writes.

---
 rtl/timer_irq.sv | 162 ++++++++++++++++
 tb/tb_timer_irq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped down-counting timer that drives one CP0 HWInt bit.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset, clears all state
//   addr   : bus byte address; [31:4] decodes the window, [3:2] selects the register
//   we     : write strobe, qualified by the address decode
//   din    : write data
//   dout   : combinational read data, 0 when the address is not in the window
//   irq    : interrupt request, CTRL.IM & flag
// Register map: 0x0 CTRL {IM, Mode[1:0], Enable}, 0x4 PRESET, 0x8 COUNT (RO), 0xC reserved.
module timer_irq #(
   parameter logic [31:0] BASE = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   localparam int unsigned DW = 32;
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] MODE_AUTO  = 2'd1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   state_t          r_state,  w_state_nxt;
   logic            r_en,     w_en_nxt;
   logic [1:0]      r_mode,   w_mode_nxt;
   logic            r_im,     w_im_nxt;
   logic [DW-1:0]   r_preset, w_preset_nxt;
   logic [DW-1:0]   r_count,  w_count_nxt;
   logic            r_flag,   w_flag_nxt;

   logic            w_sel;
   logic            w_wr_ctrl;
   logic            w_wr_preset;
   logic            w_im_only;
   logic            w_flag_clr_sw;
   logic            w_unused;

   // Address decode and write qualification
   assign w_sel       = (addr[31:4] == BASE[31:4]);
   assign w_wr_ctrl   = we & w_sel & (addr[3:2] == OFF_CTRL);
   assign w_wr_preset = we & w_sel & (addr[3:2] == OFF_PRESET);

   // A CTRL write that only toggles IM is a mask change, not an acknowledge,
   // so it leaves the flag alone; every other CTRL or PRESET write clears it.
   assign w_im_only     = (din[2:0] == {r_mode, r_en}) & (din[3] != r_im);
   assign w_flag_clr_sw = (w_wr_ctrl & ~w_im_only) | w_wr_preset;

   assign w_unused = ^addr[1:0];

   // Next-state, counter, flag and register-update logic
   always_comb begin
      logic l_flag_set;
      logic l_flag_clr_hw;
      logic l_en_clr_hw;

      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_en_nxt      = r_en;
      w_mode_nxt    = r_mode;
      w_im_nxt      = r_im;
      w_preset_nxt  = r_preset;
      w_flag_nxt    = r_flag;
      l_flag_set    = 1'b0;
      l_flag_clr_hw = 1'b0;
      l_en_clr_hw   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (r_en) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_count_nxt = r_preset;
            w_state_nxt = S_CNT;
         end
         S_CNT: begin
            if (!r_en) begin
               w_state_nxt = S_IDLE;
            end else if (r_count == '0) begin
               w_state_nxt = S_INT;
               l_flag_set  = 1'b1;
            end else begin
               w_count_nxt = r_count - DW'(1);
            end
         end
         S_INT: begin
            if (r_mode == MODE_AUTO) begin
               w_state_nxt   = S_LOAD;
               l_flag_clr_hw = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
               l_en_clr_hw = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Software CTRL write outranks the one-shot Enable clear
      if (w_wr_ctrl) begin
         w_en_nxt   = din[0];
         w_mode_nxt = din[2:1];
         w_im_nxt   = din[3];
      end else if (l_en_clr_hw) begin
         w_en_nxt = 1'b0;
      end

      if (w_wr_preset) w_preset_nxt = din;

      // Expiry outranks any clear on the same edge
      if (l_flag_clr_hw | w_flag_clr_sw) w_flag_nxt = 1'b0;
      if (l_flag_set)                    w_flag_nxt = 1'b1;
   end

   // State and register storage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_en     <= 1'b0;
         r_mode   <= 2'd0;
         r_im     <= 1'b0;
         r_preset <= '0;
         r_count  <= '0;
         r_flag   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_en     <= w_en_nxt;
         r_mode   <= w_mode_nxt;
         r_im     <= w_im_nxt;
         r_preset <= w_preset_nxt;
         r_count  <= w_count_nxt;
         r_flag   <= w_flag_nxt;
      end
   end

   // Combinational read mux
   always_comb begin
      dout = '0;
      if (w_sel) begin
         case (addr[3:2])
            OFF_CTRL:   dout = DW'({r_im, r_mode, r_en});
            OFF_PRESET: dout = r_preset;
            OFF_COUNT:  dout = r_count;
            default:    dout = '0;
         endcase
      end
   end

   // Mask is applied on the output only; drops asynchronously with reset
   assign irq = r_im & r_flag;

endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: directed and random stimulus for timer_irq, checked each cycle
// against a timeline model that tracks edges elapsed since the last LOAD.
module tb_timer_irq;

   localparam logic [31:0] BASE   = 32'h0000_7F00;
   localparam logic [31:0] A_CTRL = BASE;
   localparam logic [31:0] A_PRE  = BASE + 32'h4;
   localparam logic [31:0] A_CNT  = BASE + 32'h8;
   localparam logic [31:0] A_RSV  = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   int vectors     = 0;
   int miscompares = 0;

   timer_irq #(.BASE(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   // Reference model: m_k counts edges since LOAD was entered (-1 = idle).
   // With N latched at LOAD, k=1..N+1 are counting cycles (COUNT = N-(k-1))
   // and k=N+2 is the expiry cycle.
   logic        m_en, m_im, m_flag;
   logic [1:0]  m_mode;
   logic [31:0] m_preset, m_held;
   longint      m_k, m_n;

   task automatic m_reset();
      m_en = 1'b0; m_im = 1'b0; m_flag = 1'b0; m_mode = 2'd0;
      m_preset = '0; m_held = '0; m_k = -1; m_n = 0;
   endtask

   function automatic logic m_sel(input logic [31:0] a);
      return (a & 32'hFFFF_FFF0) == BASE;
   endfunction

   function automatic logic [31:0] m_cnt();
      if (m_k >= 1 && m_k <= m_n + 1) return 32'(m_n - (m_k - 1));
      return m_held;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [1:0] off;
      off = a[3:2];
      if (!m_sel(a)) return 32'd0;
      case (off)
         2'd0:    return {28'd0, m_im, m_mode, m_en};
         2'd1:    return m_preset;
         2'd2:    return m_cnt();
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_step(input logic [31:0] a, input logic w, input logic [31:0] d);
      logic        wr_ctrl, wr_pre, set_flag, hw_dis, hw_clr, clr_sw;
      logic [31:0] cur, nheld;
      longint      nk, nn;
      wr_ctrl  = w && m_sel(a) && (a[3:2] == 2'd0);
      wr_pre   = w && m_sel(a) && (a[3:2] == 2'd1);
      cur      = m_cnt();
      nk = m_k; nn = m_n; nheld = m_held;
      set_flag = 1'b0; hw_dis = 1'b0; hw_clr = 1'b0;
      if (m_k < 0) begin
         if (m_en) nk = 0;
      end else if (m_k == 0) begin
         nn = longint'(m_preset);
         nk = 1;
      end else if (m_k <= m_n + 1) begin
         if (!m_en) begin
            nk = -1; nheld = cur;
         end else if (m_k == m_n + 1) begin
            nk = m_n + 2; nheld = 32'd0; set_flag = 1'b1;
         end else begin
            nk = m_k + 1;
         end
      end else begin
         if (m_mode == 2'd1) begin nk = 0;  hw_clr = 1'b1; end
         else                begin nk = -1; hw_dis = 1'b1; end
      end
      clr_sw = wr_pre || (wr_ctrl && !((d[2:0] == {m_mode, m_en}) && (d[3] != m_im)));
      if (wr_ctrl)     {m_im, m_mode, m_en} = d[3:0];
      else if (hw_dis) m_en = 1'b0;
      if (wr_pre) m_preset = d;
      if (hw_clr || clr_sw) m_flag = 1'b0;
      if (set_flag) m_flag = 1'b1;
      m_k = nk; m_n = nn; m_held = nheld;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive at the falling edge, check, then clock the model.
   task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d);
      addr = a; we = w; din = d;
      #1;
      chk("dout", dout, m_read(a));
      chk("irq", 32'(irq), 32'(m_im & m_flag));
      @(posedge clk);
      m_step(a, w, d);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(A_CNT, 1'b0, 32'd0);
   endtask

   task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a; we = 1'b0;
      #1;
      chk(tag, dout, exp);
   endtask

   task automatic peek_irq(input string tag, input logic exp);
      #1;
      chk(tag, 32'(irq), 32'(exp));
   endtask

   initial begin
      int unsigned r;
      reset = 1'b0; addr = '0; we = 1'b0; din = '0;
      m_reset();
      @(negedge clk);
      peek("rst_ctrl", A_CTRL, 32'd0);
      peek("rst_preset", A_PRE, 32'd0);
      peek("rst_count", A_CNT, 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Mode 0 one-shot, PRESET=3
      step(A_PRE, 1'b1, 32'd3);
      step(A_CTRL, 1'b1, 32'h9);
      idle(2);
      peek("m0_cnt_e2", A_CNT, 32'd3);
      idle(1); peek("m0_cnt_e3", A_CNT, 32'd2);
      idle(1); peek("m0_cnt_e4", A_CNT, 32'd1);
      idle(1); peek("m0_cnt_e5", A_CNT, 32'd0);
      idle(1); peek_irq("m0_irq_e6", 1'b1);
      idle(1); peek("m0_ctrl_e7", A_CTRL, 32'h8);
      peek_irq("m0_irq_hold", 1'b1);
      step(A_PRE, 1'b1, 32'd3);
      peek_irq("m0_irq_clr", 1'b0);

      // Mode 1 auto-reload, PRESET=2: 5-cycle period
      step(A_PRE, 1'b1, 32'd2);
      step(A_CTRL, 1'b1, 32'hB);
      for (int i = 1; i <= 20; i++) begin
         idle(1);
         peek_irq("m1_irq", (i % 5) == 0);
         if ((i % 5) == 2) peek("m1_reload", A_CNT, 32'd2);
      end
      step(A_CTRL, 1'b1, 32'h0);
      idle(3);

      // Disable mid-count, then re-enable
      step(A_PRE, 1'b1, 32'd10);
      step(A_CTRL, 1'b1, 32'h9);
      idle(5);
      step(A_CTRL, 1'b1, 32'h8);
      for (int i = 0; i < 4; i++) begin
         peek("dis_hold", A_CNT, 32'd6);
         idle(1);
      end
      peek_irq("dis_irq", 1'b0);
      step(A_CTRL, 1'b1, 32'h9);
      idle(2);
      peek("dis_reload", A_CNT, 32'd10);
      step(A_CTRL, 1'b1, 32'h0);
      idle(3);

      // PRESET=0: irq three cycles after enable
      step(A_PRE, 1'b1, 32'd0);
      step(A_CTRL, 1'b1, 32'h9);
      idle(1); peek_irq("p0_e1", 1'b0);
      idle(1); peek_irq("p0_e2", 1'b0);
      idle(1); peek_irq("p0_e3", 1'b1);
      step(A_PRE, 1'b1, 32'd0);
      peek_irq("p0_clr", 1'b0);

      // Clearing CTRL write with IM=0 on the expiry edge: flag survives
      step(A_PRE, 1'b1, 32'd1);
      step(A_CTRL, 1'b1, 32'h9);
      idle(3);
      step(A_CTRL, 1'b1, 32'h0);
      peek_irq("same_irq", 1'b0);
      idle(2);
      step(A_CTRL, 1'b1, 32'h8);
      peek_irq("same_retained", 1'b1);
      step(A_PRE, 1'b1, 32'd0);

      // CTRL write in INT keeps Enable set
      step(A_CTRL, 1'b1, 32'h9);
      idle(3);
      step(A_CTRL, 1'b1, 32'h9);
      peek("ovr_ctrl", A_CTRL, 32'h9);
      idle(3);
      peek_irq("ovr_rerun", 1'b1);
      step(A_CTRL, 1'b1, 32'h0);
      idle(2);

      // Read-only, reserved and out-of-window writes
      step(A_PRE, 1'b1, 32'h1234_5678);
      step(A_CNT, 1'b1, 32'hDEAD_BEEF);
      peek("ro_count", A_CNT, 32'd0);
      step(A_RSV, 1'b1, 32'hFFFF_FFFF);
      peek("rsv_read", A_RSV, 32'd0);
      step(32'h0000_7E04, 1'b1, 32'd0);
      peek("oow_preset", A_PRE, 32'h1234_5678);
      peek("oow_read", 32'h0000_7E04, 32'd0);
      step(A_CTRL, 1'b1, 32'hFFFF_FFF0);
      peek("ctrl_upper", A_CTRL, 32'd0);

      // Reset mid-count (PRESET=5, COUNT=3)
      step(A_PRE, 1'b1, 32'd5);
      step(A_CTRL, 1'b1, 32'h9);
      idle(4);
      #1 reset = 1'b0;
      m_reset();
      peek("mid_rst_ctrl", A_CTRL, 32'd0);
      peek("mid_rst_preset", A_PRE, 32'd0);
      peek("mid_rst_count", A_CNT, 32'd0);
      chk("mid_rst_irq", 32'(irq), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      idle(4);

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 19);
         case (r)
            0, 1: step(A_CTRL, 1'b1, $urandom());
            2:    step(A_PRE, 1'b1, 32'($urandom_range(0, 8)));
            3:    step(A_CNT + 32'($urandom_range(0, 1)) * 32'd4, 1'b1, $urandom());
            4:    step(BASE + 32'h10 * 32'($urandom_range(1, 8)) + 32'($urandom_range(0, 15)),
                       1'b1, $urandom());
            default: step(BASE + 32'($urandom_range(0, 15)), 1'b0, $urandom());
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
